// File: rtl/lab_4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lab_4_pkg
//  Description : Shared types and colour codes for the lab_4 sweeper.
//  Revision    : 1.0 - initial release
// ============================================================================
package lab_4_pkg;

    localparam int DEFAULT_WIDTH = 2;

    // Colour codes ordered {red, green, blue}
    localparam logic [2:0] RGB_GT = 3'b100;
    localparam logic [2:0] RGB_EQ = 3'b010;
    localparam logic [2:0] RGB_LT = 3'b001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lab_4_expect.sv
`default_nettype none
// ============================================================================
//  Module      : lab_4_expect
//  Description : Golden comparator returning the expected one-hot colour code.
//  Revision    : 1.0 - initial release
// ============================================================================
module lab_4_expect
    import lab_4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       code
);

    always_comb begin
        if (a > b) begin
            code = RGB_GT;
        end else if (a == b) begin
            code = RGB_EQ;
        end else begin
            code = RGB_LT;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lab_4_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : lab_4_sweeper
//  Description : Sweeps every (a,b) pair, samples the colour response and
//                tallies gt/eq/lt/error counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module lab_4_sweeper
    import lab_4_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = $clog2(4**WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic               red_in,
    input  logic               green_in,
    input  logic               blue_in,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   gt_count,
    output logic [CNT_W-1:0]   eq_count,
    output logic [CNT_W-1:0]   lt_count,
    output logic [CNT_W-1:0]   err_count,
    output logic               err_flag,
    output logic [2*WIDTH-1:0] first_err_idx
);

    localparam int IDX_W = 2 * WIDTH;
    localparam int SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] c_settle_load = SET_W'(SETTLE_CYCLES);

    state_t             r_state, w_state;
    logic [IDX_W-1:0]   r_idx, w_idx;
    logic [SET_W-1:0]   r_settle, w_settle;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic [CNT_W-1:0]   r_gt, w_gt, r_eq, w_eq, r_lt, w_lt, r_err, w_err;
    logic               r_err_flag, w_err_flag;
    logic [IDX_W-1:0]   r_first_err, w_first_err;
    logic [2:0]         w_exp;
    logic [2:0]         w_sample;

    lab_4_expect #(
        .WIDTH (WIDTH)
    ) u_expect (
        .a    (r_idx[IDX_W-1:WIDTH]),
        .b    (r_idx[WIDTH-1:0]),
        .code (w_exp)
    );

    assign w_sample = {red_in, green_in, blue_in};

    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_settle    = r_settle;
        w_busy      = r_busy;
        w_done      = r_done;
        w_gt        = r_gt;
        w_eq        = r_eq;
        w_lt        = r_lt;
        w_err       = r_err;
        w_err_flag  = r_err_flag;
        w_first_err = r_first_err;

        case (r_state)
            IDLE, DONE: begin
                // A start from DONE discards the previous sweep's results
                if (start) begin
                    w_idx       = '0;
                    w_gt        = '0;
                    w_eq        = '0;
                    w_lt        = '0;
                    w_err       = '0;
                    w_err_flag  = 1'b0;
                    w_first_err = '0;
                    w_done      = 1'b0;
                    w_busy      = 1'b1;
                    w_settle    = c_settle_load;
                    w_state     = SETTLE;
                end
            end
            SETTLE: begin
                if (r_settle <= SET_W'(1)) begin
                    w_state = SAMPLE;
                end else begin
                    w_settle = r_settle - SET_W'(1);
                end
            end
            SAMPLE: begin
                if (w_sample == w_exp) begin
                    case (w_exp)
                        RGB_GT:  w_gt = r_gt + CNT_W'(1);
                        RGB_EQ:  w_eq = r_eq + CNT_W'(1);
                        RGB_LT:  w_lt = r_lt + CNT_W'(1);
                        default: ;
                    endcase
                end else begin
                    w_err = r_err + CNT_W'(1);
                    if (!r_err_flag) begin
                        w_err_flag  = 1'b1;
                        w_first_err = r_idx;
                    end
                end
                if (r_idx == {IDX_W{1'b1}}) begin
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_state = DONE;
                end else begin
                    w_idx    = r_idx + IDX_W'(1);
                    w_settle = c_settle_load;
                    w_state  = SETTLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_settle    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_gt        <= '0;
            r_eq        <= '0;
            r_lt        <= '0;
            r_err       <= '0;
            r_err_flag  <= 1'b0;
            r_first_err <= '0;
        end else begin
            r_state     <= w_state;
            r_idx       <= w_idx;
            r_settle    <= w_settle;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_gt        <= w_gt;
            r_eq        <= w_eq;
            r_lt        <= w_lt;
            r_err       <= w_err;
            r_err_flag  <= w_err_flag;
            r_first_err <= w_first_err;
        end
    end

    assign a_out         = r_idx[IDX_W-1:WIDTH];
    assign b_out         = r_idx[WIDTH-1:0];
    assign busy          = r_busy;
    assign done          = r_done;
    assign gt_count      = r_gt;
    assign eq_count      = r_eq;
    assign lt_count      = r_lt;
    assign err_count     = r_err;
    assign err_flag      = r_err_flag;
    assign first_err_idx = r_first_err;

endmodule
`default_nettype wire

// File: tb/tb_lab_4_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lab_4_sweeper
//  Description : Directed bench for lab_4_sweeper with comparator models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lab_4_sweeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start3 = 1'b0;
    int         mode = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    // DUT with SETTLE_CYCLES=1
    logic [1:0] a_out, b_out;
    logic       red, green, blue, busy, done, err_flag;
    logic [4:0] gt_count, eq_count, lt_count, err_count;
    logic [3:0] first_err_idx;
    logic [2:0] resp;

    // DUT with SETTLE_CYCLES=3
    logic [1:0] a3, b3;
    logic       red3, green3, blue3, busy3, done3, flag3;
    logic [4:0] gt3, eq3, lt3, err3;
    logic [3:0] fei3;
    logic [2:0] resp3;
    logic [1:0] ph3;

    // Golden comparator under direct test
    logic [1:0] ea, eb;
    logic [2:0] ecode;

    always #5 clk = ~clk;

    lab_4_sweeper #(.WIDTH(2), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_out(a_out), .b_out(b_out),
        .red_in(red), .green_in(green), .blue_in(blue),
        .busy(busy), .done(done),
        .gt_count(gt_count), .eq_count(eq_count), .lt_count(lt_count),
        .err_count(err_count), .err_flag(err_flag), .first_err_idx(first_err_idx)
    );

    lab_4_sweeper #(.WIDTH(2), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .a_out(a3), .b_out(b3),
        .red_in(red3), .green_in(green3), .blue_in(blue3),
        .busy(busy3), .done(done3),
        .gt_count(gt3), .eq_count(eq3), .lt_count(lt3),
        .err_count(err3), .err_flag(flag3), .first_err_idx(fei3)
    );

    lab_4_expect #(.WIDTH(2)) u_exp (.a(ea), .b(eb), .code(ecode));

    // Comparator model: 0 correct, 1 red+green at a=2,b=1, 2 all dark
    always_comb begin
        resp = {a_out > b_out, a_out == b_out, a_out < b_out};
        case (mode)
            1: if (a_out == 2'd2 && b_out == 2'd1) resp = 3'b110;
            2: resp = 3'b000;
            default: ;
        endcase
    end
    assign {red, green, blue} = resp;

    // Slow DUT sees all colours lit except on the last cycle of each pair
    always @(posedge clk) begin
        if (rst)        ph3 <= 2'd0;
        else if (busy3) ph3 <= ph3 + 2'd1;
    end
    always_comb begin
        resp3 = {a3 > b3, a3 == b3, a3 < b3};
        if (ph3 != 2'd3) resp3 = 3'b111;
    end
    assign {red3, green3, blue3} = resp3;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start3 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start3 = 1'b0;
    endtask

    // Counts busy cycles from the current negedge until done or limit
    task automatic wait_done(input bit sel, input int limit, input bit poke,
                             output int nb);
        nb = 0;
        for (int i = 0; i < limit; i++) begin
            if (sel ? done3 : done) break;
            if (sel ? busy3 : busy) nb++;
            start = poke && (nb == 5 || nb == 20);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_counts(input string tag, input int g, input int e,
                                input int l, input int er);
        check({tag, "_gt"},  int'(gt_count),  g);
        check({tag, "_eq"},  int'(eq_count),  e);
        check({tag, "_lt"},  int'(lt_count),  l);
        check({tag, "_err"}, int'(err_count), er);
    endtask

    initial begin
        int nb;
        ea = 2'd0;
        eb = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_a", int'(a_out), 0);
        check("rst_b", int'(b_out), 0);
        check("rst_flag", int'(err_flag), 0);
        check("rst_fei", int'(first_err_idx), 0);
        check_counts("rst", 0, 0, 0, 0);
        check("rst_busy3", int'(busy3), 0);

        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                ea = 2'(a);
                eb = 2'(b);
                #1;
                check("expect_code", int'(ecode),
                      (a > b) ? 4 : ((a == b) ? 2 : 1));
            end
        end

        // Correct comparator
        mode = 0;
        pulse_start(1'b0);
        check("run0_busy_c1", int'(busy), 1);
        wait_done(1'b0, 200, 1'b0, nb);
        check("run0_nbusy", nb, 32);
        check("run0_done", int'(done), 1);
        check("run0_busy_end", int'(busy), 0);
        check_counts("run0", 6, 4, 6, 0);
        check("run0_flag", int'(err_flag), 0);
        check("run0_a", int'(a_out), 3);
        check("run0_b", int'(b_out), 3);
        repeat (3) @(negedge clk);
        check("run0_hold_done", int'(done), 1);
        check("run0_hold_gt", int'(gt_count), 6);

        // Restart from DONE, with start poked mid-sweep
        pulse_start(1'b0);
        check("restart_done", int'(done), 0);
        check("restart_gt", int'(gt_count), 0);
        check("restart_busy", int'(busy), 1);
        wait_done(1'b0, 200, 1'b1, nb);
        check("poke_nbusy", nb, 32);
        check("poke_done", int'(done), 1);
        check_counts("poke", 6, 4, 6, 0);

        // Red and green both lit at a=2,b=1
        mode = 1;
        pulse_start(1'b0);
        wait_done(1'b0, 200, 1'b0, nb);
        check("fault_done", int'(done), 1);
        check_counts("fault", 5, 4, 6, 1);
        check("fault_flag", int'(err_flag), 1);
        check("fault_fei", int'(first_err_idx), 9);

        // No colour ever lit
        mode = 2;
        pulse_start(1'b0);
        wait_done(1'b0, 200, 1'b0, nb);
        check("dark_done", int'(done), 1);
        check_counts("dark", 0, 0, 0, 16);
        check("dark_flag", int'(err_flag), 1);
        check("dark_fei", int'(first_err_idx), 0);

        // Reset at busy cycle 10
        mode = 0;
        pulse_start(1'b0);
        repeat (9) @(negedge clk);
        check("mid_busy_c10", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_busy", int'(busy), 0);
        check("mid_done", int'(done), 0);
        check("mid_a", int'(a_out), 0);
        check("mid_b", int'(b_out), 0);
        check("mid_fei", int'(first_err_idx), 0);
        check_counts("mid", 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("mid_idle_busy", int'(busy), 0);
        pulse_start(1'b0);
        wait_done(1'b0, 200, 1'b0, nb);
        check("mid_rerun_nbusy", nb, 32);
        check("mid_rerun_done", int'(done), 1);
        check_counts("mid_rerun", 6, 4, 6, 0);

        // SETTLE_CYCLES=3 with glitched settle cycles
        pulse_start(1'b1);
        wait_done(1'b1, 300, 1'b0, nb);
        check("s3_nbusy", nb, 64);
        check("s3_done", int'(done3), 1);
        check("s3_gt", int'(gt3), 6);
        check("s3_eq", int'(eq3), 4);
        check("s3_lt", int'(lt3), 6);
        check("s3_err", int'(err3), 0);
        check("s3_flag", int'(flag3), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lab_4_sweeper.md
Name: lab_4_sweeper

Overview:
Sequential stimulus-and-check engine for the driving side of the lab_4 colour comparator interface.
- On start, it steps through every (a, b) operand pair and drives them onto a_out/b_out.
- After a settle delay it samples the red/green/blue responses and checks them against an internal expected comparison.
- It tallies greater/equal/less/error counts and raises done. It replaces the bench-only nested loop with synthesizable self-test hardware.
- Interface contract: red means a>b, green means a==b, blue means a<b. Exactly one colour is high for any pair.

Parameters:
- WIDTH, 2, operand width of a and b; the sweep covers 4**WIDTH pairs.
- SETTLE_CYCLES, 1, cycles each pair is held before sampling; must be >=1.
- CNT_W, $clog2(4**WIDTH+1), width of the tally counters (5 at defaults).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle request to begin a sweep.
- a_out  out  WIDTH  operand a to the comparator.
- b_out  out  WIDTH  operand b to the comparator.
- red_in  in  1  comparator red response.
- green_in  in  1  comparator green response.
- blue_in  in  1  comparator blue response.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; level signal.
- gt_count  out  CNT_W  number of samples with red alone high.
- eq_count  out  CNT_W  number of samples with green alone high.
- lt_count  out  CNT_W  number of samples with blue alone high.
- err_count  out  CNT_W  number of samples not matching the expected one-hot colour.
- err_flag  out  1  at least one error this sweep.
- first_err_idx  out  2*WIDTH  {a,b} index of the first erroring pair; valid only when err_flag=1.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0 (a_out, b_out, busy, done, all counts, err_flag, first_err_idx); state IDLE.
- Sweep index idx is 2*WIDTH bits: a_out = idx[2W-1:W] and b_out = idx[W-1:0]. b is the inner (fast) variable, so the order is a=0,b=0..3, then a=1,b=0..3, and so on. All outputs are registered.
- States:
  - IDLE: busy=0. When start=1: idx<=0, counters and err state cleared, done<=0, settle counter<=SETTLE_CYCLES, go to SETTLE.
  - SETTLE: busy=1, operands held stable. Counter decrements each cycle; the state lasts exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
  - SAMPLE: busy=1, one cycle. Sample {red_in,green_in,blue_in} and compare with the expected one-hot code from the current a_out/b_out.
    - On match, increment the matching gt/eq/lt counter.
    - On mismatch (wrong colour, zero, or multiple high), increment err_count only. If err_flag=0, set err_flag and latch first_err_idx<=idx.
    - If idx is all ones, go to DONE. Otherwise idx<=idx+1, reload the settle counter, go to SETTLE.
  - DONE: busy=0, done=1. Counters and a_out/b_out (last pair) hold. start=1 restarts exactly as from IDLE, with done dropping the next cycle.
- Timing: start is sampled at edge 0 and busy=1 from cycle 1. Each pair takes SETTLE_CYCLES+1 cycles. done rises after 4**WIDTH*(SETTLE_CYCLES+1) busy cycles, which is 32 at defaults.
- start while busy is ignored.
- rst has priority over everything. Mid-sweep it returns to IDLE and clears all outputs the next cycle; no partial results are retained.
- Counters never overflow: the maximum 4**WIDTH fits in CNT_W.
- For a correct comparator, gt+eq+lt = 4**WIDTH with eq = 2**WIDTH and gt = lt = (4**WIDTH - 2**WIDTH)/2. At defaults this is 6/4/6.

Decomposition:
- Package lab_4_pkg:
  - state enum {IDLE, SETTLE, SAMPLE, DONE}.
  - colour code constants RGB_GT=3'b100, RGB_EQ=3'b010, RGB_LT=3'b001, ordered {red,green,blue}.
  - default WIDTH.
- One sub-module: lab_4_expect, a combinational golden comparator. It takes a and b and returns the 3-bit expected colour code. It is reused by the bench scoreboard.

Test Plan:
- Correct comparator model, SETTLE_CYCLES=1, start pulse → busy high for 32 cycles, then done=1, gt=6, eq=4, lt=6, err=0, err_flag=0, a_out=3, b_out=3.
- Faulty model that forces green=1 when a=2,b=1 (red and green both high) → err_count=1, first_err_idx=4'b1001, gt=5, eq=4, lt=6.
- Model returning 3'b000 for all pairs → err_count=16, err_flag=1, first_err_idx=0, gt=eq=lt=0.
- Assert rst at busy cycle 10 → next cycle all outputs 0 and state IDLE. A new start then completes with gt=6/eq=4/lt=6.
- start pulsed again at cycles 5 and 20 while busy → ignored, done still at busy cycle 32. start in DONE → done=0 next cycle and counts cleared.
- SETTLE_CYCLES=3 → each pair held 4 cycles, done after 64 busy cycles. Sampling happens only on the final cycle of each pair: a response glitched during the first 3 cycles is not counted.
